// File: rtl/picorv32_native_mem.sv
// PicoRV32 native-interface memory slave: byte-strobed word RAM, wait states, address window, tohost MMIO.
// Optional zero preload when NATIVE_MEM_PRELOAD_EN is defined.
module picorv32_native_mem #(
  parameter int          DEPTH_WORDS = 512,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 0,
  parameter logic [31:0] TOHOST_ADDR = 32'h1000_0000,
  parameter string       INIT_FILE   = "prog.hex"
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        done,
  output logic        pass,
  output logic [31:0] tohost_code,
  output logic        err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [1:0]  state_dbg
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_LOAD = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

  // Handshake: a request is taken only in IDLE on mem_valid=1; mem_ready is a
  // one-cycle strobe in RESP carrying mem_rdata; the request is then complete.
  typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [31:0]   off;
  logic          in_win;
  logic          is_tohost;
  logic          is_wr;
  logic          commit;
  logic [AW-1:0] idx;

  logic [31:0] ram [DEPTH_WORDS];

  logic unused_in;
  assign unused_in = ^{mem_instr, mem_addr[1:0]};

  assign state_dbg = state;

  // BASE_ADDR is window-aligned, so the low word-address bits index the RAM directly.
  always_comb begin
    off       = {addr_q, 2'b00} - BASE_ADDR;
    in_win    = ({1'b0, off} < WIN_BYTES);
    is_tohost = (addr_q == TOHOST_ADDR[31:2]);
    is_wr     = |wstrb_q;
    idx       = addr_q[AW-1:0];
    commit    = ((state == ACC) && (LATENCY == 0)) ||
                ((state == WAIT) && (wait_cnt == 4'd0));
  end

  always_ff @(posedge clk) begin
    if (resetn && commit && is_wr && in_win && !is_tohost) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) ram[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

`ifdef NATIVE_MEM_PRELOAD_EN
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) ram[i] = 32'h0;
  end
`else
  // Without preload the RAM powers up unknown; software must write before reading.
`endif

  // ACC is a fixed accept cycle, so the response lands one edge after capture plus LATENCY.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      addr_q      <= 30'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      mem_ready   <= 1'b0;
      mem_rdata   <= 32'd0;
      done        <= 1'b0;
      pass        <= 1'b0;
      tohost_code <= 32'd0;
      err         <= 1'b0;
      rd_count    <= 32'd0;
      wr_count    <= 32'd0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            addr_q  <= mem_addr[31:2];
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            state   <= ACC;
          end
        end
        ACC: begin
          if (commit) begin
            state     <= RESP;
            mem_ready <= 1'b1;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (commit) begin
            state     <= RESP;
            mem_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (commit) begin
        if (is_wr) begin
          wr_count <= wr_count + 32'd1;
          if (is_tohost) begin
            done <= 1'b1;
            if (!done) begin
              tohost_code <= wdata_q;
              pass        <= (wdata_q == 32'h1);
            end
          end else if (!in_win) begin
            err <= 1'b1;
          end
        end else begin
          rd_count <= rd_count + 32'd1;
          if (is_tohost || !in_win) begin
            mem_rdata <= 32'd0;
            err       <= 1'b1;
          end else begin
            mem_rdata <= ram[idx];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_picorv32_native_mem.sv
// Bench for picorv32_native_mem: one instance with LATENCY=0, one with LATENCY=3.
// Expected read data goes through a scoreboard queue checked on each mem_ready.
module tb_picorv32_native_mem;

  localparam logic [31:0] TOHOST = 32'h1000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn    [2];
  logic        mem_valid [2];
  logic        mem_instr [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wstrb [2];
  logic        mem_ready [2];
  logic [31:0] mem_rdata [2];
  logic        done      [2];
  logic        pass      [2];
  logic [31:0] tohost_code [2];
  logic        err       [2];
  logic [31:0] rd_count  [2];
  logic [31:0] wr_count  [2];
  logic [1:0]  state_dbg [2];

  int cmp_cnt = 0;
  int mis_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl [2][512];
  logic [31:0] last_rd [2];
  logic [31:0] exp_rd [2];
  logic [31:0] exp_wr [2];

  picorv32_native_mem #(.LATENCY(0)) dut0 (
    .clk(clk), .resetn(resetn[0]), .mem_valid(mem_valid[0]), .mem_instr(mem_instr[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
    .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]), .done(done[0]), .pass(pass[0]),
    .tohost_code(tohost_code[0]), .err(err[0]), .rd_count(rd_count[0]),
    .wr_count(wr_count[0]), .state_dbg(state_dbg[0])
  );

  picorv32_native_mem #(.LATENCY(3)) dut1 (
    .clk(clk), .resetn(resetn[1]), .mem_valid(mem_valid[1]), .mem_instr(mem_instr[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
    .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]), .done(done[1]), .pass(pass[1]),
    .tohost_code(tohost_code[1]), .err(err[1]), .rd_count(rd_count[1]),
    .wr_count(wr_count[1]), .state_dbg(state_dbg[1])
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Drive one request, hold valid until mem_ready, score rdata, check strobe width.
  task automatic do_req(input int s, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_data, output int lat);
    logic [31:0] exp;
    exp_q.push_back(exp_data);
    @(negedge clk);
    mem_addr[s]  = addr;
    mem_wdata[s] = wdata;
    mem_wstrb[s] = strb;
    mem_instr[s] = (strb == 4'd0) ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_valid[s] = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_ready[s] && lat < 40);
    mem_valid[s] = 1'b0;
    exp = exp_q.pop_front();
    cmp_cnt++;
    if (mem_ready[s] !== 1'b1) begin
      mis_cnt++;
      $display("FAIL ready_timeout dut%0d addr=%h: no mem_ready after %0d cycles", s, addr, lat);
      return;
    end
    if (mem_rdata[s] !== exp) begin
      mis_cnt++;
      $display("FAIL rdata dut%0d addr=%h: got %h expected %h", s, addr, mem_rdata[s], exp);
    end
    @(posedge clk); #1;
    cmp_cnt++;
    if (mem_ready[s] !== 1'b0) begin
      mis_cnt++;
      $display("FAIL ready_width dut%0d: got %b expected 0", s, mem_ready[s]);
    end
  endtask

  task automatic wr(input int s, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, output int lat);
    do_req(s, addr, data, strb, last_rd[s], lat);
    exp_wr[s]++;
    if (addr < 32'h800) mdl[s][addr[10:2]] = merge(mdl[s][addr[10:2]], data, strb);
  endtask

  task automatic rd(input int s, input logic [31:0] addr, output int lat);
    logic [31:0] e;
    e = (addr < 32'h800) ? mdl[s][addr[10:2]] : 32'h0;
    last_rd[s] = e;
    do_req(s, addr, 32'h0, 4'h0, e, lat);
    exp_rd[s]++;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      resetn[s] = 1'b0; mem_valid[s] = 1'b0; mem_instr[s] = 1'b0;
      mem_addr[s] = 32'h0; mem_wdata[s] = 32'h0; mem_wstrb[s] = 4'h0;
      last_rd[s] = 32'h0; exp_rd[s] = 32'h0; exp_wr[s] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn[0] = 1'b1; resetn[1] = 1'b1;
    for (int s = 0; s < 2; s++) begin
      cmp_cnt += 9;
      if (mem_ready[s] !== 1'b0) begin mis_cnt++; $display("FAIL rst_ready dut%0d: got %b expected 0", s, mem_ready[s]); end
      if (mem_rdata[s] !== 32'h0) begin mis_cnt++; $display("FAIL rst_rdata dut%0d: got %h expected 0", s, mem_rdata[s]); end
      if (done[s] !== 1'b0) begin mis_cnt++; $display("FAIL rst_done dut%0d: got %b expected 0", s, done[s]); end
      if (pass[s] !== 1'b0) begin mis_cnt++; $display("FAIL rst_pass dut%0d: got %b expected 0", s, pass[s]); end
      if (err[s] !== 1'b0) begin mis_cnt++; $display("FAIL rst_err dut%0d: got %b expected 0", s, err[s]); end
      if (tohost_code[s] !== 32'h0) begin mis_cnt++; $display("FAIL rst_code dut%0d: got %h expected 0", s, tohost_code[s]); end
      if (rd_count[s] !== 32'h0) begin mis_cnt++; $display("FAIL rst_rd_count dut%0d: got %0d expected 0", s, rd_count[s]); end
      if (wr_count[s] !== 32'h0) begin mis_cnt++; $display("FAIL rst_wr_count dut%0d: got %0d expected 0", s, wr_count[s]); end
      if (state_dbg[s] !== 2'd0) begin mis_cnt++; $display("FAIL rst_state dut%0d: got %0d expected 0", s, state_dbg[s]); end
    end
  endtask

  task automatic test_latency0();
    int lat;
    logic [31:0] a;
    wr(0, 32'h40, 32'hA5A5_1234, 4'hF, lat);
    cmp_cnt++;
    if (lat != 1) begin mis_cnt++; $display("FAIL lat0_write: got %0d expected 1", lat); end
    rd(0, 32'h40, lat);
    cmp_cnt++;
    if (lat != 1) begin mis_cnt++; $display("FAIL lat0_read: got %0d expected 1", lat); end
    for (int i = 0; i < 6; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 63)) * 4;
      wr(0, a, 32'hFFFF_FFFF, 4'hF, lat);
      wr(0, a, $urandom, 4'($urandom_range(1, 15)), lat);
      rd(0, a, lat);
    end
  endtask

  task automatic test_strobes();
    int lat;
    wr(0, 32'h44, 32'h1122_3344, 4'hF, lat);
    wr(0, 32'h44, 32'hFFFF_FFFF, 4'b0101, lat);
    rd(0, 32'h44, lat);
    cmp_cnt += 3;
    if (mem_rdata[0] !== 32'h11FF_33FF) begin mis_cnt++; $display("FAIL strobe_merge: got %h expected 11ff33ff", mem_rdata[0]); end
    if (rd_count[0] !== exp_rd[0]) begin mis_cnt++; $display("FAIL strobe_rd_count: got %0d expected %0d", rd_count[0], exp_rd[0]); end
    if (wr_count[0] !== exp_wr[0]) begin mis_cnt++; $display("FAIL strobe_wr_count: got %0d expected %0d", wr_count[0], exp_wr[0]); end
  endtask

  task automatic test_latency3();
    int lat;
    wr(1, 32'h80, 32'h0BAD_F00D, 4'hF, lat);
    cmp_cnt++;
    if (lat != 4) begin mis_cnt++; $display("FAIL lat3_write: got %0d expected 4", lat); end
    rd(1, 32'h80, lat);
    cmp_cnt++;
    if (lat != 4) begin mis_cnt++; $display("FAIL lat3_read: got %0d expected 4", lat); end
  endtask

  // mem_valid held high across RESP: the second request starts only from IDLE.
  task automatic test_back_to_back();
    int lat1, lat2;
    logic [31:0] e;
    exp_q.push_back(mdl[1][32]);
    exp_q.push_back(mdl[1][32]);
    @(negedge clk);
    mem_addr[1] = 32'h80; mem_wstrb[1] = 4'h0; mem_wdata[1] = 32'h0; mem_valid[1] = 1'b1;
    @(posedge clk);
    lat1 = 0;
    do begin @(posedge clk); #1; lat1++; end while (!mem_ready[1] && lat1 < 40);
    e = exp_q.pop_front();
    cmp_cnt += 2;
    if (lat1 != 4) begin mis_cnt++; $display("FAIL b2b_first_lat: got %0d expected 4", lat1); end
    if (mem_rdata[1] !== e) begin mis_cnt++; $display("FAIL b2b_first_data: got %h expected %h", mem_rdata[1], e); end
    lat2 = 0;
    do begin @(posedge clk); #1; lat2++; end while (!mem_ready[1] && lat2 < 40);
    mem_valid[1] = 1'b0;
    e = exp_q.pop_front();
    exp_rd[1] += 2;
    cmp_cnt += 3;
    if (lat2 != 6) begin mis_cnt++; $display("FAIL b2b_gap: got %0d expected 6", lat2); end
    if (mem_rdata[1] !== e) begin mis_cnt++; $display("FAIL b2b_second_data: got %h expected %h", mem_rdata[1], e); end
    if (rd_count[1] !== exp_rd[1]) begin mis_cnt++; $display("FAIL b2b_rd_count: got %0d expected %0d", rd_count[1], exp_rd[1]); end
    last_rd[1] = e;
    @(posedge clk); #1;
  endtask

  task automatic test_window();
    int lat;
    wr(0, 32'h0, 32'h1234_5678, 4'hF, lat);
    rd(0, 32'h0, lat);
    cmp_cnt++;
    if (err[0] !== 1'b0) begin mis_cnt++; $display("FAIL win_err_before: got %b expected 0", err[0]); end
    rd(0, 32'h800, lat);
    cmp_cnt += 2;
    if (err[0] !== 1'b1) begin mis_cnt++; $display("FAIL win_err_read: got %b expected 1", err[0]); end
    if (lat != 1) begin mis_cnt++; $display("FAIL win_ready: got %0d expected 1", lat); end
    wr(0, 32'h800, 32'hDEAD_BEEF, 4'hF, lat);
    rd(0, 32'h0, lat);
  endtask

  task automatic test_tohost();
    int lat;
    cmp_cnt++;
    if (done[0] !== 1'b0) begin mis_cnt++; $display("FAIL tohost_done_before: got %b expected 0", done[0]); end
    wr(0, TOHOST, 32'h1, 4'hF, lat);
    cmp_cnt += 3;
    if (done[0] !== 1'b1) begin mis_cnt++; $display("FAIL tohost_done: got %b expected 1", done[0]); end
    if (pass[0] !== 1'b1) begin mis_cnt++; $display("FAIL tohost_pass: got %b expected 1", pass[0]); end
    if (tohost_code[0] !== 32'h1) begin mis_cnt++; $display("FAIL tohost_code: got %h expected 1", tohost_code[0]); end
    wr(0, TOHOST, 32'h7, 4'hF, lat);
    cmp_cnt += 3;
    if (tohost_code[0] !== 32'h1) begin mis_cnt++; $display("FAIL tohost_code_second: got %h expected 1", tohost_code[0]); end
    if (pass[0] !== 1'b1) begin mis_cnt++; $display("FAIL tohost_pass_second: got %b expected 1", pass[0]); end
    if (wr_count[0] !== exp_wr[0]) begin mis_cnt++; $display("FAIL tohost_wr_count: got %0d expected %0d", wr_count[0], exp_wr[0]); end
    cmp_cnt++;
    if (err[1] !== 1'b0) begin mis_cnt++; $display("FAIL tohost_rd_err_before: got %b expected 0", err[1]); end
    rd(1, TOHOST, lat);
    cmp_cnt += 2;
    if (err[1] !== 1'b1) begin mis_cnt++; $display("FAIL tohost_rd_err: got %b expected 1", err[1]); end
    if (done[1] !== 1'b0) begin mis_cnt++; $display("FAIL tohost_rd_done: got %b expected 0", done[1]); end
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    @(negedge clk);
    mem_addr[1] = 32'h80; mem_wdata[1] = 32'hCAFE_F00D; mem_wstrb[1] = 4'hF; mem_valid[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    resetn[1] = 1'b0; mem_valid[1] = 1'b0;
    @(posedge clk); #1;
    cmp_cnt += 4;
    if (mem_ready[1] !== 1'b0) begin mis_cnt++; $display("FAIL midrst_ready: got %b expected 0", mem_ready[1]); end
    if (state_dbg[1] !== 2'd0) begin mis_cnt++; $display("FAIL midrst_state: got %0d expected 0", state_dbg[1]); end
    if (rd_count[1] !== 32'h0) begin mis_cnt++; $display("FAIL midrst_rd_count: got %0d expected 0", rd_count[1]); end
    if (wr_count[1] !== 32'h0) begin mis_cnt++; $display("FAIL midrst_wr_count: got %0d expected 0", wr_count[1]); end
    @(negedge clk);
    resetn[1] = 1'b1;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (mem_ready[1]) seen++; end
    cmp_cnt++;
    if (seen != 0) begin mis_cnt++; $display("FAIL midrst_ready_after: got %0d pulses expected 0", seen); end
    exp_rd[1] = 32'h0; exp_wr[1] = 32'h0; last_rd[1] = 32'h0;
    rd(1, 32'h80, lat);
    cmp_cnt++;
    if (rd_count[1] !== 32'h1) begin mis_cnt++; $display("FAIL midrst_rd_count_after: got %0d expected 1", rd_count[1]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency0();
    test_strobes();
    test_latency3();
    test_back_to_back();
    test_window();
    test_tohost();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
